mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction fetch path and the load/store unit.
- Serialises one outstanding transaction at a time. Load/store has priority, with a fetch anti-starvation limit.
- Drives fetch_halt, which gates PC advance so the PC moves only when an instruction word is delivered.
- A response timeout keeps the pipeline from hanging on a dead memory.

Parameters:
- XLEN, 32, address/data width (matches `XLEN).
- DATA_STREAK_MAX, 4, maximum consecutive load/store grants while fetch waits; range 1..15.
- TIMEOUT, 64, cycles to wait for mem_rvalid after mem_req; 0 disables the timeout; range 0..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  XLEN  fetch address (PC)
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  instruction word valid (1-cycle pulse)
- if_rdata  out  XLEN  instruction word
- if_err  out  1  qualifies if_rvalid: fetch timed out
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1=store, 0=load
- ls_be  in  4  byte enables
- ls_addr  in  XLEN  data address
- ls_wdata  in  XLEN  store data
- ls_gnt  out  1  load/store accepted (1-cycle pulse)
- ls_rvalid  out  1  load data / store ack (1-cycle pulse)
- ls_rdata  out  XLEN  load data
- ls_err  out  1  qualifies ls_rvalid: access timed out
- mem_req  out  1  memory request (1-cycle pulse)
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data
- mem_rvalid  in  1  memory response/ack
- fetch_halt  out  1  halt to the fetch stage

Behaviour:
- FSM states: IDLE, IF_BUSY, LS_BUSY.
- Reset values: state=IDLE; streak=0; timeout counter=0; latched request fields=0. All outputs are 0 except fetch_halt=1.

Arbitration (in IDLE, cycle T):
- ls_req only -> grant LS.
- if_req only -> grant IF.
- Both asserted -> grant LS, unless streak==DATA_STREAK_MAX, in which case grant IF.
- Streak counter:
  - +1 on an LS grant made while if_req=1.
  - Cleared on an IF grant.
  - Cleared on any LS grant made while if_req=0.
  - Saturates at DATA_STREAK_MAX.

Grant timing:
- Request fields are registered at T.
- At T+1: state moves to IF_BUSY or LS_BUSY; mem_req=1 for exactly that cycle with the latched address/we/be/wdata; the matching gnt pulses in the same cycle.
- IF transactions force mem_we=0 and mem_be=4'hF.
- mem_addr, mem_we, mem_be and mem_wdata hold the latched values while BUSY and are 0 in IDLE.

Response:
- In a BUSY state, mem_rvalid=1 passes through combinationally in the same cycle:
  - IF_BUSY: if_rvalid=1, if_rdata=mem_rdata.
  - LS_BUSY: ls_rvalid=1, ls_rdata=mem_rdata.
- The FSM returns to IDLE the next cycle.
- rdata is 0 whenever its rvalid=0. Stores also return ls_rvalid as the ack; ls_rdata is don't-care on stores.
- The earliest response is at T+2. The minimum spacing between grants is 3 cycles.

Timeout:
- The counter is loaded at mem_req and counts BUSY cycles without mem_rvalid.
- When the count reaches TIMEOUT, the owner's rvalid=1 and err=1, with rdata=0, and the FSM goes to IDLE.
- mem_rvalid arriving in the same cycle as expiry wins: normal response, err=0.
- mem_rvalid received while in IDLE is ignored (stale response dropped).

fetch_halt:
- fetch_halt = NOT (state==IF_BUSY AND if_rvalid AND NOT if_err). The PC advances exactly once per delivered instruction.
- On a fetch timeout, fetch_halt stays 1 and fetch re-requests.

Other boundary conditions:
- Requests arriving while BUSY wait; they are never dropped.
- Reset mid-transaction returns the FSM to IDLE immediately. No rvalid is emitted for the aborted access; its late response is dropped.
- With DATA_STREAK_MAX=1, simultaneous requests alternate LS, IF, LS, IF.

Test Plan:
- Single fetch, if_addr=0x10, memory responds 2 cycles after mem_req with 0x00500093 -> mem_req=1 with mem_addr=0x10 at T+1; if_rvalid=1 and if_rdata=0x00500093 at T+3; fetch_halt=0 for only that cycle.
- Store then load: ls_we=1, ls_addr=0x100, ls_wdata=0xDEADBEEF, ls_be=4'hF, then ls_we=0 at the same address -> mem_we=1 on the first grant only; second ls_rvalid carries 0xDEADBEEF; grants are ≥3 cycles apart.
- if_req and ls_req held high continuously with DATA_STREAK_MAX=4 -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Memory never responds, TIMEOUT=8 -> ls_rvalid=1, ls_err=1, ls_rdata=0 exactly 8 cycles after mem_req; a late mem_rvalid 3 cycles later produces no rvalid.
- rst_n=0 asserted during IF_BUSY -> next cycle: state IDLE, fetch_halt=1, no if_rvalid; a subsequent mem_rvalid is ignored.
- mem_rvalid coincides with the timeout-expiry cycle -> normal response with err=0 and rdata=mem_rdata.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the unified memory port: fetch, load/store and memory sides.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            if_err;
    logic            ls_req;
    logic            ls_we;
    logic [3:0]      ls_be;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [XLEN-1:0] ls_rdata;
    logic            ls_err;
    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid;
    logic            fetch_halt;

    // slave is the arbiter's view; master is the surrounding core and memory
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata, mem_rvalid,
        output if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, fetch_halt
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata, mem_rvalid,
        input  if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, fetch_halt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one transaction in flight, with fetch anti-starvation and a response timeout.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int DATA_STREAK_MAX = 4,
    parameter int TIMEOUT         = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    // state   | meaning
    // IDLE    | port free, arbitrating pending requests
    // IF_BUSY | fetch transaction outstanding
    // LS_BUSY | load/store transaction outstanding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);
    localparam logic [7:0] TMO_LOAD   = 8'(TIMEOUT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_streak;
    logic [7:0]      r_tmo;
    logic            r_req_pulse;
    logic            r_we;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;

    logic w_busy;
    logic w_rsp;
    logic w_expire;
    logic w_done;
    logic w_grant_ls;
    logic w_grant_if;

    // Responses are masked while rst_n is low so an aborted access never completes.
    assign w_busy     = (r_state != IDLE);
    assign w_rsp      = w_busy && bus.mem_rvalid && rst_n;
    assign w_expire   = w_busy && (TMO_LOAD != 8'd0) && (r_tmo == 8'd0) && rst_n;
    assign w_done     = w_rsp || w_expire;
    assign w_grant_ls = (r_state == IDLE) && bus.ls_req && !(bus.if_req && (r_streak == STREAK_MAX));
    assign w_grant_if = (r_state == IDLE) && bus.if_req && !w_grant_ls;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_ls) begin
                    w_state_nxt = LS_BUSY;
                end else if (w_grant_if) begin
                    w_state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Timeout is a down-counter loaded on grant; terminal count zero means expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_streak    <= '0;
            r_tmo       <= '0;
            r_req_pulse <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_req_pulse <= w_grant_ls || w_grant_if;
            if (w_grant_ls) begin
                r_we    <= bus.ls_we;
                r_be    <= bus.ls_be;
                r_addr  <= bus.ls_addr;
                r_wdata <= bus.ls_wdata;
                r_tmo   <= TMO_LOAD;
                if (!bus.if_req) begin
                    r_streak <= '0;
                end else if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + 4'd1;
                end
            end else if (w_grant_if) begin
                r_we     <= 1'b0;
                r_be     <= 4'hF;
                r_addr   <= bus.if_addr;
                r_wdata  <= '0;
                r_tmo    <= TMO_LOAD;
                r_streak <= '0;
            end else if (w_done) begin
                r_tmo <= '0;
            end else if (w_busy && (r_tmo != 8'd0)) begin
                r_tmo <= r_tmo - 8'd1;
            end
        end
    end

    always_comb begin
        bus.if_gnt     = 1'b0;
        bus.if_rvalid  = 1'b0;
        bus.if_err     = 1'b0;
        bus.if_rdata   = '0;
        bus.ls_gnt     = 1'b0;
        bus.ls_rvalid  = 1'b0;
        bus.ls_err     = 1'b0;
        bus.ls_rdata   = '0;
        bus.mem_req    = r_req_pulse;
        bus.mem_we     = 1'b0;
        bus.mem_be     = 4'h0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.fetch_halt = 1'b1;
        if (w_busy) begin
            bus.mem_we    = r_we;
            bus.mem_be    = r_be;
            bus.mem_addr  = r_addr;
            bus.mem_wdata = r_wdata;
        end
        case (r_state)
            IF_BUSY: begin
                bus.if_gnt     = r_req_pulse;
                bus.if_rvalid  = w_done;
                bus.if_err     = w_expire && !w_rsp;
                bus.if_rdata   = w_rsp ? bus.mem_rdata : '0;
                bus.fetch_halt = !w_rsp;
            end
            LS_BUSY: begin
                bus.ls_gnt    = r_req_pulse;
                bus.ls_rvalid = w_done;
                bus.ls_err    = w_expire && !w_rsp;
                bus.ls_rdata  = w_rsp ? bus.mem_rdata : '0;
            end
            default: ;
        endcase
    end
endmodule
